// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock parametrised FIFO between the SPI slave and the RAM/host side.
// Any depth >= 2 is supported. The write and read pointers wrap explicitly at FIFO_DEPTH-1.
// The almost-full and almost-empty thresholds are programmable, and the occupancy count is an output.
// The read mode is either standard (registered) or first-word-fall-through.
// Optional feature macro: SYNC_FIFO_HWM_EN adds a high-water-mark output (hwm) and its clear input (hwm_clr).
module sync_fifo_param #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int AF_THR     = FIFO_DEPTH - 1,
    parameter int AE_THR     = 1,
    parameter int FWFT       = 0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [FIFO_WIDTH-1:0]             data_in,
    input  logic                              wr_en,
    input  logic                              rd_en,
    output logic [FIFO_WIDTH-1:0]             data_out,
    output logic                              valid,
    output logic                              wr_ack,
    output logic                              overflow,
    output logic                              underflow,
    output logic                              full,
    output logic                              empty,
    output logic                              almostfull,
    output logic                              almostempty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   count
`ifdef SYNC_FIFO_HWM_EN
    ,
    input  logic                              hwm_clr,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   hwm
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] AF_C     = CW'(AF_THR);
    localparam logic [CW-1:0] AE_C     = CW'(AE_THR);

    // Pointer increment that wraps at the last storage slot, so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PTR_LAST) begin
            return {PW{1'b0}};
        end else begin
            return p + PW'(1'b1);
        end
    endfunction

    logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q,  count_d;
    logic                  wr_ack_q, overflow_q, underflow_q;
    logic                  full_s, empty_s, rd_acc_s, wr_acc_s;

    assign full_s   = (count_q == CNT_FULL);
    assign empty_s  = (count_q == {CW{1'b0}});
    assign rd_acc_s = rd_en & ~empty_s;
    // In FWFT mode, a pop frees a slot in the same cycle, so a write to a full FIFO can still be taken.
    assign wr_acc_s = wr_en & (~full_s | ((FWFT != 0) & rd_acc_s));

    // Next-state computation for the pointers and the occupancy count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc_s) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_acc_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_d = count_q + CW'(1'b1);
            2'b01:   count_d = count_q - CW'(1'b1);
            default: count_d = count_q;
        endcase
    end

    // Control state and the one-cycle status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= {PW{1'b0}};
            rd_ptr_q    <= {PW{1'b0}};
            count_q     <= {CW{1'b0}};
            wr_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            wr_ack_q    <= wr_acc_s;
            overflow_q  <= wr_en & ~wr_acc_s;
            underflow_q <= rd_en & empty_s;
        end
    end

    // Storage write. The contents need no reset because the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr_acc_s && !rst) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    assign wr_ack      = wr_ack_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;
    assign full        = full_s;
    assign empty       = empty_s;
    assign almostfull  = (count_q >= AF_C) && !full_s;
    assign almostempty = !empty_s && (count_q <= AE_C);
    assign count       = count_q;

    generate
        if (FWFT != 0) begin : g_fwft
            // The head word is presented directly and is forced to zero while the FIFO is empty.
            assign data_out = empty_s ? {FIFO_WIDTH{1'b0}} : mem_q[rd_ptr_q];
            assign valid    = ~empty_s;
        end else begin : g_std
            logic [FIFO_WIDTH-1:0] dout_q;
            logic                  valid_q;
            // Registered read: capture the head word on each accepted read; otherwise hold the last value.
            always_ff @(posedge clk) begin
                if (rst) begin
                    dout_q  <= {FIFO_WIDTH{1'b0}};
                    valid_q <= 1'b0;
                end else begin
                    if (rd_acc_s) begin
                        dout_q <= mem_q[rd_ptr_q];
                    end
                    valid_q <= rd_acc_s;
                end
            end
            assign data_out = dout_q;
            assign valid    = valid_q;
        end
    endgenerate

`ifdef SYNC_FIFO_HWM_EN
    logic [CW-1:0] hwm_q;
    // High-water mark: track the peak registered count. hwm_clr rebases it to the present occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            hwm_q <= {CW{1'b0}};
        end else if (hwm_clr) begin
            hwm_q <= count_q;
        end else if (count_q > hwm_q) begin
            hwm_q <= count_q;
        end
    end
    assign hwm = hwm_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Testbench for sync_fifo_param. It uses three instances:
// standard mode with depth 8, standard mode with depth 6 (pointer wrap), and FWFT mode with depth 8.
module tb_sync_fifo_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Standard mode, depth 8
    logic [15:0] s_din, s_dout;
    logic        s_wr, s_rd, s_vld, s_ack, s_ovf, s_unf, s_ful, s_emp, s_af, s_ae;
    logic [3:0]  s_cnt;
    // Standard mode, depth 6
    logic [15:0] d_din, d_dout;
    logic        d_wr, d_rd, d_vld, d_ack, d_ovf, d_unf, d_ful, d_emp, d_af, d_ae;
    logic [2:0]  d_cnt;
    // FWFT mode, depth 8
    logic [15:0] f_din, f_dout;
    logic        f_wr, f_rd, f_vld, f_ack, f_ovf, f_unf, f_ful, f_emp, f_af, f_ae;
    logic [3:0]  f_cnt;
`ifdef SYNC_FIFO_HWM_EN
    logic        s_hclr, d_hclr, f_hclr;
    logic [3:0]  s_hwm, f_hwm;
    logic [2:0]  d_hwm;
`endif

    sync_fifo_param #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .AF_THR(7), .AE_THR(1), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .data_in(s_din), .wr_en(s_wr), .rd_en(s_rd), .data_out(s_dout),
        .valid(s_vld), .wr_ack(s_ack), .overflow(s_ovf), .underflow(s_unf), .full(s_ful),
        .empty(s_emp), .almostfull(s_af), .almostempty(s_ae), .count(s_cnt)
`ifdef SYNC_FIFO_HWM_EN
        , .hwm_clr(s_hclr), .hwm(s_hwm)
`endif
    );

    sync_fifo_param #(.FIFO_WIDTH(16), .FIFO_DEPTH(6), .AF_THR(5), .AE_THR(1), .FWFT(0)) u_d6 (
        .clk(clk), .rst(rst), .data_in(d_din), .wr_en(d_wr), .rd_en(d_rd), .data_out(d_dout),
        .valid(d_vld), .wr_ack(d_ack), .overflow(d_ovf), .underflow(d_unf), .full(d_ful),
        .empty(d_emp), .almostfull(d_af), .almostempty(d_ae), .count(d_cnt)
`ifdef SYNC_FIFO_HWM_EN
        , .hwm_clr(d_hclr), .hwm(d_hwm)
`endif
    );

    sync_fifo_param #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .AF_THR(7), .AE_THR(1), .FWFT(1)) u_fw (
        .clk(clk), .rst(rst), .data_in(f_din), .wr_en(f_wr), .rd_en(f_rd), .data_out(f_dout),
        .valid(f_vld), .wr_ack(f_ack), .overflow(f_ovf), .underflow(f_unf), .full(f_ful),
        .empty(f_emp), .almostfull(f_af), .almostempty(f_ae), .count(f_cnt)
`ifdef SYNC_FIFO_HWM_EN
        , .hwm_clr(f_hclr), .hwm(f_hwm)
`endif
    );

    // Flag vector order: {empty, full, almostfull, almostempty, valid, wr_ack, overflow, underflow}
    typedef struct {
        logic        rst;
        logic        wr;
        logic        rd;
        logic [15:0] din;
        logic [3:0]  cnt;
        logic [7:0]  flg;
        logic [15:0] dout;
    } vec_t;

    vec_t vecs[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic vec_t mk(input logic r, input logic w, input logic rd, input logic [15:0] din,
                                input logic [3:0] cnt, input logic [7:0] flg, input logic [15:0] dout);
        vec_t v;
        v.rst = r; v.wr = w; v.rd = rd; v.din = din; v.cnt = cnt; v.flg = flg; v.dout = dout;
        return v;
    endfunction

    function automatic logic [7:0] fl(input logic e, input logic f, input logic af, input logic ae,
                                      input logic v, input logic a, input logic o, input logic u);
        return {e, f, af, ae, v, a, o, u};
    endfunction

    task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got 0x%h, want 0x%h", nm, idx, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        s_wr = 1'b0; s_rd = 1'b0; s_din = 16'h0;
        d_wr = 1'b0; d_rd = 1'b0; d_din = 16'h0;
        f_wr = 1'b0; f_rd = 1'b0; f_din = 16'h0;
`ifdef SYNC_FIFO_HWM_EN
        s_hclr = 1'b0; d_hclr = 1'b0; f_hclr = 1'b0;
`endif

        // Reset asserted with wr_en and rd_en high, then one idle cycle
        vecs.push_back(mk(1'b1, 1'b1, 1'b1, 16'h0, 4'd0, fl(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0), 16'h0));
        vecs.push_back(mk(1'b1, 1'b1, 1'b1, 16'h0, 4'd0, fl(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0), 16'h0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0, 4'd0, fl(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0), 16'h0));
        // Fill with 0x0001..0x0008
        for (int k = 1; k <= 8; k++)
            vecs.push_back(mk(1'b0, 1'b1, 1'b0, 16'(k), 4'(k),
                              fl(1'b0, k == 8, k == 7, k == 1, 1'b0, 1'b1, 1'b0, 1'b0), 16'h0));
        // Ninth write is rejected, then the overflow pulse drops
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 16'h9, 4'd8, fl(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0), 16'h0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0, 4'd8, fl(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0), 16'h0));
        // Drain in order
        for (int k = 1; k <= 8; k++)
            vecs.push_back(mk(1'b0, 1'b0, 1'b1, 16'h0, 4'(8 - k),
                              fl(k == 8, 1'b0, k == 1, k == 7, 1'b1, 1'b0, 1'b0, 1'b0), 16'(k)));
        // Read while empty gives underflow; data_out holds its last value
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 16'h0, 4'd0, fl(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1), 16'h8));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0, 4'd0, fl(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0), 16'h8));
        // Write and read together while empty: the write is taken, the read underflows, and there is no bypass
        vecs.push_back(mk(1'b0, 1'b1, 1'b1, 16'h55, 4'd1, fl(1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b1), 16'h8));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 16'h0, 4'd0, fl(1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0), 16'h55));
        // Refill with 0x10..0x17
        for (int k = 0; k < 8; k++)
            vecs.push_back(mk(1'b0, 1'b1, 1'b0, 16'h10 + 16'(k), 4'(k + 1),
                              fl(1'b0, k == 7, k == 6, k == 0, 1'b0, 1'b1, 1'b0, 1'b0), 16'h55));
        // Full with write and read together: the read is taken and the write overflows
        vecs.push_back(mk(1'b0, 1'b1, 1'b1, 16'h18, 4'd7, fl(1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b1,1'b0), 16'h10));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0, 4'd7, fl(1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0), 16'h10));

        foreach (vecs[i]) begin
            rst = vecs[i].rst; s_wr = vecs[i].wr; s_rd = vecs[i].rd; s_din = vecs[i].din;
            step();
            chk("std_count", i, 16'(s_cnt), 16'(vecs[i].cnt));
            chk("std_flags", i, 16'({s_emp, s_ful, s_af, s_ae, s_vld, s_ack, s_ovf, s_unf}), 16'(vecs[i].flg));
            chk("std_dout",  i, s_dout, vecs[i].dout);
        end
        rst = 1'b0; s_wr = 1'b0; s_rd = 1'b0;

        // Depth 6: preload 3 words, then 20 cycles of simultaneous read and write
        for (int k = 1; k <= 3; k++) begin
            d_wr = 1'b1; d_din = 16'(k);
            step();
        end
        chk("d6_preload_count", 0, 16'(d_cnt), 16'd3);
        for (int i = 0; i < 20; i++) begin
            d_wr = 1'b1; d_rd = 1'b1; d_din = 16'(4 + i);
            step();
            chk("d6_count", i, 16'(d_cnt), 16'd3);
            chk("d6_valid", i, 16'(d_vld), 16'd1);
            chk("d6_dout",  i, d_dout, 16'(1 + i));
        end
        d_wr = 1'b0; d_rd = 1'b0;

        // FWFT: a write into an empty FIFO falls through without rd_en
        f_wr = 1'b1; f_din = 16'hBEEF;
        step();
        f_wr = 1'b0;
        chk("fw_ft_valid", 0, 16'(f_vld), 16'd1);
        chk("fw_ft_dout",  0, f_dout, 16'hBEEF);
        chk("fw_ft_count", 0, 16'(f_cnt), 16'd1);
        step();
        chk("fw_hold_dout", 0, f_dout, 16'hBEEF);
        f_rd = 1'b1;
        step();
        f_rd = 1'b0;
        chk("fw_pop_valid", 0, 16'(f_vld), 16'd0);
        chk("fw_pop_empty", 0, 16'(f_emp), 16'd1);
        for (int k = 0; k < 8; k++) begin
            f_wr = 1'b1; f_din = 16'hA0 + 16'(k);
            step();
        end
        f_wr = 1'b0;
        chk("fw_full", 0, 16'(f_ful), 16'd1);
        chk("fw_head", 0, f_dout, 16'hA0);
        // Full with write and read together in FWFT mode: both are taken
        f_wr = 1'b1; f_rd = 1'b1; f_din = 16'hA8;
        step();
        f_wr = 1'b0; f_rd = 1'b0;
        chk("fw_both_count", 0, 16'(f_cnt), 16'd8);
        chk("fw_both_ack",   0, 16'(f_ack), 16'd1);
        chk("fw_both_ovf",   0, 16'(f_ovf), 16'd0);
        chk("fw_both_dout",  0, f_dout, 16'hA1);
        for (int k = 0; k < 8; k++) begin
            chk("fw_drain_dout",  k, f_dout, 16'hA1 + 16'(k));
            chk("fw_drain_valid", k, 16'(f_vld), 16'd1);
            f_rd = 1'b1;
            step();
        end
        f_rd = 1'b0;
        chk("fw_end_empty", 0, 16'(f_emp), 16'd1);
        chk("fw_end_valid", 0, 16'(f_vld), 16'd0);

`ifdef SYNC_FIFO_HWM_EN
        // High-water mark: fill to 5, drain to 2, then clear
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("hwm_reset", 0, 16'(s_hwm), 16'd0);
        for (int k = 0; k < 5; k++) begin
            s_wr = 1'b1; s_din = 16'(k);
            step();
        end
        s_wr = 1'b0;
        for (int k = 0; k < 3; k++) begin
            s_rd = 1'b1;
            step();
        end
        s_rd = 1'b0;
        step();
        chk("hwm_count", 0, 16'(s_cnt), 16'd2);
        chk("hwm_peak",  0, 16'(s_hwm), 16'd5);
        s_hclr = 1'b1;
        step();
        s_hclr = 1'b0;
        chk("hwm_clr", 0, 16'(s_hwm), 16'd2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
